// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory responder that sits behind the multicycle control FSM's
//   load/store request lines. It accepts one request per armed request level
//   and waits LATENCY cycles. It then performs one access to a word-organised
//   local RAM, with RV32I byte/half/word lane handling, and returns a
//   one-cycle ready pulse.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   en_fetch_data  load request level
//   en_store_data  store request level (wins when both are high)
//   func3          RV32I width code (B/H/W/BU/HU)
//   addr           byte address; bits above the RAM size are ignored
//   wdata          store data, lane-aligned to bit 0
//   rdata          extended load result, held between responses
//   ready          one-cycle completion pulse
//   busy           high from accept through the ready cycle
//   err            valid with ready: misaligned access or illegal func3
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_fetch_data,
    input  logic        en_store_data,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          armed_q, armed_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    func3_q, func3_d;
    logic          isStore_q, isStore_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] wordIdx;
    logic [31:0]   ramWord;
    logic [31:0]   shiftedWord;
    logic [31:0]   loadValue;
    logic [31:0]   laneData;
    logic [31:0]   mergedWord;
    logic [3:0]    byteEn;
    logic          loadErr, storeErr, accessErr;
    logic          requestSeen;
    logic          unusedAddrBits;

    // The address wraps modulo the RAM size, so the upper bits are dropped on purpose.
    assign unusedAddrBits = ^addr[31:AW+2];

    assign requestSeen = en_fetch_data | en_store_data;
    assign wordIdx     = addr_q[AW+1:2];
    assign ramWord     = mem[wordIdx];
    assign shiftedWord = ramWord >> {addr_q[1:0], 3'b000};

    // Alignment and func3 legality, evaluated on the captured request.
    always_comb begin
        loadErr  = 1'b1;
        storeErr = 1'b1;
        case (func3_q)
            3'b000, 3'b100: loadErr = 1'b0;
            3'b001, 3'b101: loadErr = addr_q[0];
            3'b010:         loadErr = |addr_q[1:0];
            default:        loadErr = 1'b1;
        endcase
        case (func3_q)
            3'b000:  storeErr = 1'b0;
            3'b001:  storeErr = addr_q[0];
            3'b010:  storeErr = |addr_q[1:0];
            default: storeErr = 1'b1;
        endcase
        accessErr = isStore_q ? storeErr : loadErr;
    end

    // Load lane extraction. A legal halfword has addr[0]=0, so shifting by the
    // full byte offset lands the selected half at bit 0.
    always_comb begin
        loadValue = 32'd0;
        case (func3_q)
            3'b000:  loadValue = {{24{shiftedWord[7]}}, shiftedWord[7:0]};
            3'b001:  loadValue = {{16{shiftedWord[15]}}, shiftedWord[15:0]};
            3'b010:  loadValue = ramWord;
            3'b100:  loadValue = {24'd0, shiftedWord[7:0]};
            3'b101:  loadValue = {16'd0, shiftedWord[15:0]};
            default: loadValue = 32'd0;
        endcase
    end

    // Store merge: replicate the lane data across the word and overwrite only the enabled bytes.
    always_comb begin
        byteEn   = 4'b1111;
        laneData = wdata_q;
        case (func3_q[1:0])
            2'b00: begin
                byteEn   = 4'b0001 << addr_q[1:0];
                laneData = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                byteEn   = addr_q[1] ? 4'b1100 : 4'b0011;
                laneData = {2{wdata_q[15:0]}};
            end
            default: begin
                byteEn   = 4'b1111;
                laneData = wdata_q;
            end
        endcase
        mergedWord = ramWord;
        for (int b = 0; b < 4; b++) begin
            if (byteEn[b]) begin
                mergedWord[8*b +: 8] = laneData[8*b +: 8];
            end
        end
    end

    // Next-state and output logic. armed re-arms only when both request lines
    // are low, so a level held across RESP is never accepted twice.
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        busy_d    = busy_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        func3_d   = func3_q;
        isStore_d = isStore_q;

        if (!requestSeen) begin
            armed_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (armed_q && requestSeen) begin
                    addr_d    = addr[AW+1:0];
                    wdata_d   = wdata;
                    func3_d   = func3;
                    isStore_d = en_store_data;
                    armed_d   = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = WAIT_INIT;
                    state_d   = (LATENCY == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                ready_d = 1'b1;
                err_d   = accessErr;
                if (!isStore_q) begin
                    rdata_d = accessErr ? 32'd0 : loadValue;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            func3_q   <= 3'd0;
            isStore_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            func3_q   <= func3_d;
            isStore_q <= isStore_d;
        end
    end

    // RAM has no reset. A reset abort moves state_q out of ACCESS at once, so no write is committed.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && isStore_q && !accessErr) begin
            mem[wordIdx] <= mergedWord;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Randomised and directed bench for data_mem_responder (LATENCY=2, 256 words).
//   Expected results come from a byte-level memory model held in the bench.
module tb_data_mem_responder;

    localparam int DEPTH   = 256;
    localparam int LAT     = 2;
    localparam int WINDOW  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_fetch_data;
    logic        en_store_data;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] modelMem [DEPTH];
    logic [31:0] lastRdata = 32'd0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .en_fetch_data (en_fetch_data),
        .en_store_data (en_store_data),
        .func3         (func3),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .ready         (ready),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Single point of comparison; counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Reference model: byte-addressed view of the RAM with RV32I size/alignment rules.
    task automatic modelRun(input bit isStore, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, output logic expErr, output logic [31:0] expData);
        int idx, off, size;
        logic [31:0] mask, raw;
        idx  = int'((a / 4) % DEPTH);
        off  = int'(a % 4);
        size = 1 << f3[1:0];
        if (isStore) expErr = (f3 > 3'd2);
        else         expErr = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        if (!expErr && (off % size) != 0) expErr = 1'b1;
        if (isStore) begin
            if (!expErr) begin
                for (int b = 0; b < size; b++) begin
                    modelMem[idx][8*(off+b) +: 8] = d[8*b +: 8];
                end
            end
            expData = lastRdata;
        end else begin
            if (expErr) begin
                expData = 32'd0;
            end else begin
                mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
                raw  = (modelMem[idx] >> (8*off)) & mask;
                if (f3[2] == 1'b0 && size < 4 && raw[8*size-1]) raw = raw | ~mask;
                expData = raw;
            end
            lastRdata = expData;
        end
    endtask

    // One full transaction with a fixed observation window, so nothing can hang.
    task automatic applyStimulus(input bit isStore, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] d, output logic [31:0] gotData, output logic gotErr);
        logic        expErr;
        logic [31:0] expData;
        int          readyAt, pulses, busyCycles;
        modelRun(isStore, f3, a, d, expErr, expData);
        @(negedge clk);
        en_fetch_data = !isStore;
        en_store_data = isStore;
        func3 = f3;
        addr  = a;
        wdata = d;
        readyAt = 0; pulses = 0; busyCycles = 0;
        gotData = 32'd0; gotErr = 1'b0;
        for (int c = 1; c <= WINDOW; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                en_fetch_data = 1'b0;
                en_store_data = 1'b0;
            end
            if (busy) busyCycles++;
            if (ready) begin
                pulses++;
                if (readyAt == 0) begin
                    readyAt = c;
                    gotData = rdata;
                    gotErr  = err;
                end
            end
        end
        checkOutput("latency", 32'(readyAt), 32'(LAT + 2));
        checkOutput("busy_cycles", 32'(busyCycles), 32'(LAT + 2));
        checkOutput("ready_pulses", 32'(pulses), 32'd1);
        checkOutput("err", {31'd0, gotErr}, {31'd0, expErr});
        checkOutput(isStore ? "store_rdata_hold" : "load_rdata", gotData, expData);
    endtask

    initial begin
        logic [31:0] gd;
        logic        ge, expErr;
        logic [31:0] expData;
        int          pulses;

        rst = 1'b0;
        en_fetch_data = 1'b0; en_store_data = 1'b0;
        func3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_ready", {31'd0, ready}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fill the whole RAM so every later load has a known reference.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 3'b010, 32'(i * 4), $urandom, gd, ge);
        end

        // Directed: word store/load round trip.
        applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, gd, ge);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, gd, ge);
        checkOutput("lw_deadbeef", gd, 32'hDEADBEEF);

        // Directed: byte store and signed/unsigned byte loads.
        applyStimulus(1'b1, 3'b010, 32'h10, 32'h0, gd, ge);
        applyStimulus(1'b1, 3'b000, 32'h13, 32'h80, gd, ge);
        applyStimulus(1'b0, 3'b000, 32'h13, 32'd0, gd, ge);
        checkOutput("lb_signext", gd, 32'hFFFFFF80);
        applyStimulus(1'b0, 3'b100, 32'h13, 32'd0, gd, ge);
        checkOutput("lbu_zeroext", gd, 32'h00000080);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, gd, ge);
        checkOutput("lw_after_sb", gd, 32'h80000000);

        // Directed: misaligned accesses report err and leave memory alone.
        applyStimulus(1'b1, 3'b001, 32'h21, 32'hBEEF, gd, ge);
        checkOutput("sh_misaligned_err", {31'd0, ge}, 32'd1);
        applyStimulus(1'b0, 3'b010, 32'h22, 32'd0, gd, ge);
        checkOutput("lw_misaligned_err", {31'd0, ge}, 32'd1);
        checkOutput("lw_misaligned_data", gd, 32'd0);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'd0, gd, ge);

        // Directed: address wrap modulo RAM size.
        applyStimulus(1'b1, 3'b010, 32'h400, 32'h12345678, gd, ge);
        applyStimulus(1'b0, 3'b010, 32'h000, 32'd0, gd, ge);
        checkOutput("wrap_lw", gd, 32'h12345678);

        // Held request level must be accepted only once.
        modelRun(1'b0, 3'b010, 32'h10, 32'd0, expErr, expData);
        @(negedge clk);
        en_fetch_data = 1'b1; func3 = 3'b010; addr = 32'h10;
        pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                pulses++;
                checkOutput("held_rdata", rdata, expData);
            end
        end
        checkOutput("held_single_pulse", 32'(pulses), 32'd1);
        @(negedge clk);
        en_fetch_data = 1'b0;
        @(negedge clk);
        en_fetch_data = 1'b1;
        modelRun(1'b0, 3'b010, 32'h10, 32'd0, expErr, expData);
        pulses = 0;
        for (int c = 1; c <= WINDOW; c++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                pulses++;
                checkOutput("rearm_rdata", rdata, expData);
            end
        end
        checkOutput("rearm_pulse", 32'(pulses), 32'd1);
        @(negedge clk);
        en_fetch_data = 1'b0;
        @(negedge clk);

        // Reset during WAIT of a store: abort at once, nothing written.
        @(negedge clk);
        en_store_data = 1'b1; func3 = 3'b010; addr = 32'h30; wdata = ~modelMem[12];
        @(posedge clk);
        #1;
        en_store_data = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_ready", {31'd0, ready}, 32'd0);
        checkOutput("abort_err", {31'd0, err}, 32'd0);
        checkOutput("abort_rdata", rdata, 32'd0);
        lastRdata = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 3'b010, 32'h30, 32'd0, gd, ge);

        // Random mix of loads and stores, legal and illegal, with wrapping addresses.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, gd, ge);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder on the far side of the multicycle control FSM's load/store request lines (en_fetch_data / en_store_data).
- Accepts one load or store per request, holds a word-organised local RAM, and inserts configurable wait states.
- Performs RV32I byte/half/word lane selection, sign/zero extension and byte-masked writes.
- Returns a one-cycle ready pulse with load data or an error flag.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in RAM (power of 2, 4..4096).
- LATENCY, 2, wait-state cycles between accept and access (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- en_fetch_data  in  1  load request level from control FSM.
- en_store_data  in  1  store request level from control FSM.
- func3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2 value), lane-aligned to bit 0.
- rdata  out  32  extended load result.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high from accept until ready cycle inclusive.
- err  out  1  valid with ready: misaligned or illegal func3; access suppressed.

Behaviour:
- Reset values: state IDLE; rdata 0; ready 0; busy 0; err 0; armed 1. RAM contents are not reset.
- Reset asserted in any state aborts immediately. No RAM write occurs unless the ACCESS edge has already completed.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: on a rising edge with armed=1 and (en_fetch_data | en_store_data), the block accepts the request.
  - Captures addr, wdata, func3 and op. If both enables are high, store wins.
  - Clears armed and sets busy.
  - Goes to WAIT, or to ACCESS if LATENCY=0.
- WAIT: a counter loaded with LATENCY-1 decrements each cycle. At 0 the FSM goes to ACCESS.
- ACCESS (1 cycle): RAM read or write at the closing edge, then RESP.
- RESP (1 cycle): ready=1, err valid, rdata updated for loads, then IDLE. busy drops after RESP.
- armed is set again only when both enables are sampled low. A request level held across RESP therefore is never re-accepted (no double access).
- Latency: accept edge E, then ready is high during cycle E+LATENCY+2 (counting the cycle after E as 1).
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so the address wraps modulo DEPTH_WORDS*4.
- Error cases (err=1, no write, rdata forced to 0 for loads):
  - H/HU/SH with addr[0]=1.
  - W/SW with addr[1:0]≠00.
  - load func3 in {011, 110, 111}.
  - store func3 > 010.
- Loads:
  - B/BU select byte lane addr[1:0]; H/HU select half-word lane addr[1].
  - B and H sign-extend from the lane MSB; BU and HU zero-extend.
  - W returns the whole word.
- Stores:
  - SB writes wdata[7:0] into lane addr[1:0].
  - SH writes wdata[15:0] into half-word lane addr[1].
  - SW writes all four lanes.
  - Unselected bytes are preserved.
- Store responses leave rdata unchanged. rdata holds its value between responses.
- ready, busy and err are registered outputs. No combinational path from inputs to outputs.

Test Plan:
- LATENCY=2: SW 0xDEADBEEF at 0x10, then LW 0x10 → ready in cycle E+4 each, rdata=0xDEADBEEF, err=0, busy high exactly 4 cycles.
- SB 0x80 at 0x13 over word 0x00000000, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80000000.
- SH at 0x21, then LW at 0x22 → each gives ready with err=1; RAM word at 0x20 unchanged; load rdata=0.
- en_fetch_data held high for 10 cycles → exactly one ready pulse. Drop the enable for 1 cycle, raise it again → second access accepted.
- DEPTH_WORDS=256: SW 0x12345678 to 0x400, then LW 0x000 → 0x12345678 (wrap).
- Assert rst during WAIT of an SW → outputs return to reset values at once; a following LW of that address returns the prior contents (no write committed).
